marker_interval_monitor: RTL and testbench
==========================================

Name:
marker_interval_monitor

Overview:
Downstream consumer of the FA/SA marker produced by the event synchronizer; one instance per marker.
- Detects each marker rising edge and latches the EVR timestamp at that edge.
- Measures the interval in evrClk cycles between successive markers and keeps min/max/count statistics.
- Flags intervals outside a programmable tolerance window.
- All outputs are evrClk-domain registers. The system side reads them after seeing updateToggle change.

Parameters:
INTERVAL_WIDTH, 29, width of interval counter and statistics (covers the 300000000 SA reload).
COUNT_WIDTH, 16, width of markerCount and errorCount.
TIMESTAMP_WIDTH, 64, width of EVR timestamp (seconds:ticks).
TOL_WIDTH, 12, width of tolerance input.

Ports:
evrClk  input  1  clock.
sysCSRstrobe  input  1  reset, asynchronous, active-high; clears all statistics.
marker  input  1  stretched marker from event synchronizer (high >=1 cycle, low >=1 cycle between pulses).
evrTimestamp  input  TIMESTAMP_WIDTH  free-running EVR timestamp.
expectedInterval  input  INTERVAL_WIDTH  nominal period in evrClk cycles, quasi-static; 0 disables checking.
tolerance  input  TOL_WIDTH  allowed |interval-expected| in cycles.
markerTimestamp  output  TIMESTAMP_WIDTH  timestamp at most recent edge.
lastInterval  output  INTERVAL_WIDTH  most recent interval.
minInterval  output  INTERVAL_WIDTH  smallest valid interval since reset.
maxInterval  output  INTERVAL_WIDTH  largest valid interval since reset.
markerCount  output  COUNT_WIDTH  edges since reset, saturating.
errorCount  output  COUNT_WIDTH  out-of-tolerance or overflowed intervals, saturating.
intervalError  output  1  sticky; set on any error.
intervalValid  output  1  high once at least one interval has been measured.
updateToggle  output  1  inverts on every output update.

Behaviour:
Reset values:
- markerTimestamp, lastInterval, maxInterval, markerCount, errorCount = 0.
- minInterval = all-ones.
- intervalError, intervalValid, updateToggle = 0.
- marker_d = 1, so a marker already high at reset release is not counted as an edge.
- State = IDLE, interval counter = 0, ovf flag = 0.

Edge detect:
- edge = marker && !marker_d, evaluated in cycle n.
- All output updates for that edge are registered at the clock edge ending cycle n, so they are visible in cycle n+1 (1-cycle latency).
- updateToggle inverts on that same clock edge.

Interval counter:
- On an edge, the counter loads 1.
- Otherwise it increments, saturating at all-ones; saturation sets the ovf flag.
- Edges at cycles n and n+P therefore measure interval P.

State machine:
- IDLE: counter held at 0.
  - On edge: latch timestamp, markerCount+1, go to ARMED.
  - No interval is recorded on this first edge.
- ARMED/RUN, on edge:
  - Latch timestamp and increment markerCount.
  - lastInterval = counter value, or all-ones if ovf.
  - Set intervalValid; state = RUN; clear ovf.
- Valid interval (not ovf): update minInterval = min(min, P) and maxInterval = max(max, P).
- Overflowed interval:
  - Excluded from min/max.
  - Always counts as an error.
  - Always reported in lastInterval as all-ones.

Error check:
- Applies when expectedInterval != 0 and the interval is valid.
- error if |P - expectedInterval| > tolerance.
- Compute the difference at INTERVAL_WIDTH+1 bits signed; no wrap.
- On error: errorCount+1 (saturating) and intervalError <= 1.

Saturation and width rules:
- markerCount and errorCount stick at all-ones.
- Statistics never wrap.

Reset mid-operation:
- Asserting sysCSRstrobe forces all reset values immediately, regardless of state.
- The first edge after release behaves as from IDLE.

Simultaneous events:
- An edge in the same cycle the counter saturates: ovf is considered set, so the interval is treated as overflowed.
- Changes to expectedInterval or tolerance take effect at the next edge's check.
- No CDC handling on these inputs; a momentary misjudged interval is acceptable.

Test Plan:
- Reset, then marker pulses (3 cycles high) at cycles 10, 110, 210, 310 with expected=100, tol=0 -> markerCount=4, lastInterval=min=max=100, errorCount=0, intervalValid=1, updateToggle toggled 4 times, each update visible 1 cycle after the edge.
- Intervals 100, 98, 105 with expected=100, tol=3 -> min=98, max=105, errorCount=1, intervalError=1.
- Marker held high through reset release -> no count until the next rising edge; markerCount=0, updateToggle=0.
- INTERVAL_WIDTH=8 bench, edges 300 cycles apart -> lastInterval=255, errorCount=1, min/max unchanged from reset values (255/0), next 50-cycle interval gives min=max=50.
- sysCSRstrobe pulsed mid-interval after 5 markers -> all outputs return to reset values immediately; the following two edges yield markerCount=2 and a single interval.
- evrTimestamp = 0x0000_0012_0000_0100 ramping at the edge cycle -> markerTimestamp equals the timestamp sampled in the edge-detect cycle; expected=0 -> errorCount stays 0 for any interval.

Source files
------------

// File: rtl/marker_interval_monitor_if.sv
// marker_interval_monitor_if
// Bundles everything a marker_interval_monitor instance exchanges with its
// surroundings apart from clock and reset.
//   master : the producer side (event synchronizer / CSR block). It drives the
//            marker, timestamp and check configuration and reads the statistics.
//   slave  : the monitor itself.
// Signals:
//   marker            stretched marker pulse (high >=1 cycle, low >=1 cycle)
//   evrTimestamp      free-running EVR timestamp (seconds:ticks)
//   expectedInterval  nominal marker period in evrClk cycles, 0 disables checking
//   tolerance         allowed |interval - expectedInterval| in cycles
//   markerTimestamp   timestamp latched at the most recent marker edge
//   lastInterval      most recent interval (all-ones when it overflowed)
//   minInterval       smallest non-overflowed interval since reset
//   maxInterval       largest non-overflowed interval since reset
//   markerCount       rising edges since reset, saturating
//   errorCount        out-of-tolerance or overflowed intervals, saturating
//   intervalError     sticky error flag
//   intervalValid     at least one interval has been measured
//   updateToggle      inverts whenever the outputs above are updated
//   fsm_state         debug view of the monitor state machine
interface marker_interval_monitor_if #(
    parameter int INTERVAL_WIDTH  = 29,
    parameter int COUNT_WIDTH     = 16,
    parameter int TIMESTAMP_WIDTH = 64,
    parameter int TOL_WIDTH       = 12
);
    logic                       marker;
    logic [TIMESTAMP_WIDTH-1:0] evrTimestamp;
    logic [INTERVAL_WIDTH-1:0]  expectedInterval;
    logic [TOL_WIDTH-1:0]       tolerance;

    logic [TIMESTAMP_WIDTH-1:0] markerTimestamp;
    logic [INTERVAL_WIDTH-1:0]  lastInterval;
    logic [INTERVAL_WIDTH-1:0]  minInterval;
    logic [INTERVAL_WIDTH-1:0]  maxInterval;
    logic [COUNT_WIDTH-1:0]     markerCount;
    logic [COUNT_WIDTH-1:0]     errorCount;
    logic                       intervalError;
    logic                       intervalValid;
    logic                       updateToggle;
    logic [1:0]                 fsm_state;

    modport master (
        output marker, evrTimestamp, expectedInterval, tolerance,
        input  markerTimestamp, lastInterval, minInterval, maxInterval,
               markerCount, errorCount, intervalError, intervalValid,
               updateToggle, fsm_state
    );

    modport slave (
        input  marker, evrTimestamp, expectedInterval, tolerance,
        output markerTimestamp, lastInterval, minInterval, maxInterval,
               markerCount, errorCount, intervalError, intervalValid,
               updateToggle, fsm_state
    );
endinterface

// File: rtl/marker_interval_monitor.sv
// marker_interval_monitor
// Watches one FA/SA marker in the evrClk domain. On every rising edge of the
// marker it latches the EVR timestamp, measures the number of evrClk cycles
// since the previous edge, maintains min/max/count statistics and flags
// intervals outside expectedInterval +/- tolerance. All outputs are registers;
// the system side samples them after seeing updateToggle change.
// Ports:
//   evrClk        clock
//   sysCSRstrobe  asynchronous active-high reset, clears all statistics
//   mon           slave side of marker_interval_monitor_if (see that file)
// Timing: an edge seen in cycle n updates every output on the clock edge that
// ends cycle n, so the new values are visible in cycle n+1.
module marker_interval_monitor #(
    parameter int INTERVAL_WIDTH  = 29,
    parameter int COUNT_WIDTH     = 16,
    parameter int TIMESTAMP_WIDTH = 64,
    parameter int TOL_WIDTH       = 12
) (
    input  logic                    evrClk,
    input  logic                    sysCSRstrobe,
    marker_interval_monitor_if.slave mon
);
    localparam logic [INTERVAL_WIDTH-1:0] IMAX = '1;
    localparam logic [INTERVAL_WIDTH-1:0] IONE = INTERVAL_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]    CMAX = '1;
    localparam logic [COUNT_WIDTH-1:0]    CONE = COUNT_WIDTH'(1);
    // Deviation and tolerance are compared at a width that holds both.
    localparam int CMP_W = (INTERVAL_WIDTH + 1 > TOL_WIDTH) ? INTERVAL_WIDTH + 1 : TOL_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no edge seen since reset
        ARMED = 2'd1,   // first edge seen, first interval running
        RUN   = 2'd2    // at least one interval recorded
    } state_t;

    state_t                    state;
    logic                      marker_d;
    logic [INTERVAL_WIDTH-1:0] counter;
    logic                      ovf;

    logic                      rise;
    logic                      ovf_now;
    logic signed [INTERVAL_WIDTH:0] diff;
    logic [INTERVAL_WIDTH:0]   abs_diff;
    logic [CMP_W-1:0]          abs_ext;
    logic [CMP_W-1:0]          tol_ext;
    logic                      out_of_tol;
    logic                      interval_err;

    assign rise = mon.marker & ~marker_d;

    // A counter sitting at all-ones has saturated even if the sticky flag is
    // only set on the following clock, so an edge in that cycle counts as an
    // overflowed interval.
    assign ovf_now = ovf | (counter == IMAX);

    // One extra bit keeps the signed difference exact over the full range.
    assign diff     = $signed({1'b0, counter}) - $signed({1'b0, mon.expectedInterval});
    assign abs_diff = diff[INTERVAL_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    assign abs_ext  = CMP_W'(abs_diff);
    assign tol_ext  = CMP_W'(mon.tolerance);

    assign out_of_tol   = (mon.expectedInterval != '0) && (abs_ext > tol_ext);
    assign interval_err = ovf_now | out_of_tol;

    assign mon.fsm_state = state;

    always_ff @(posedge evrClk or posedge sysCSRstrobe) begin
        if (sysCSRstrobe) begin
            state               <= IDLE;
            // Held high so a marker already asserted at release is not an edge.
            marker_d            <= 1'b1;
            counter             <= '0;
            ovf                 <= 1'b0;
            mon.markerTimestamp <= '0;
            mon.lastInterval    <= '0;
            mon.minInterval     <= IMAX;
            mon.maxInterval     <= '0;
            mon.markerCount     <= '0;
            mon.errorCount      <= '0;
            mon.intervalError   <= 1'b0;
            mon.intervalValid   <= 1'b0;
            mon.updateToggle    <= 1'b0;
        end else begin
            marker_d <= mon.marker;
            case (state)
                IDLE: begin
                    counter <= '0;
                    ovf     <= 1'b0;
                    if (rise) begin
                        // First edge only arms the measurement.
                        counter             <= IONE;
                        mon.markerTimestamp <= mon.evrTimestamp;
                        mon.updateToggle    <= ~mon.updateToggle;
                        if (mon.markerCount != CMAX) begin
                            mon.markerCount <= mon.markerCount + CONE;
                        end
                        state <= ARMED;
                    end
                end
                ARMED, RUN: begin
                    if (rise) begin
                        counter             <= IONE;
                        ovf                 <= 1'b0;
                        mon.markerTimestamp <= mon.evrTimestamp;
                        mon.updateToggle    <= ~mon.updateToggle;
                        mon.intervalValid   <= 1'b1;
                        if (mon.markerCount != CMAX) begin
                            mon.markerCount <= mon.markerCount + CONE;
                        end
                        if (ovf_now) begin
                            mon.lastInterval <= IMAX;
                        end else begin
                            mon.lastInterval <= counter;
                            if (counter < mon.minInterval) begin
                                mon.minInterval <= counter;
                            end
                            if (counter > mon.maxInterval) begin
                                mon.maxInterval <= counter;
                            end
                        end
                        if (interval_err) begin
                            mon.intervalError <= 1'b1;
                            if (mon.errorCount != CMAX) begin
                                mon.errorCount <= mon.errorCount + CONE;
                            end
                        end
                        state <= RUN;
                    end else if (counter != IMAX) begin
                        counter <= counter + IONE;
                    end else begin
                        ovf <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_marker_interval_monitor.sv
// tb_marker_interval_monitor
// Drives a 29-bit-interval monitor (dut0) and an 8-bit-interval monitor (dut1)
// with directed marker sequences. The driver pushes the expected output record
// for each marker edge into a per-DUT queue; a monitor process pops and
// compares whenever updateToggle changes. Hand-computed end-of-scenario values
// are checked directly by the driver.
module tb_marker_interval_monitor;
    localparam int          TS_W     = 64;
    localparam logic [63:0] TS_BASE  = 64'h0000_0012_0000_0100;
    localparam logic [63:0] WIDE_MAX = 64'h1FFF_FFFF;
    localparam logic [63:0] NARR_MAX = 64'hFF;

    typedef struct {
        int          vis;
        logic [63:0] ts;
        logic [63:0] last;
        logic [63:0] mn;
        logic [63:0] mx;
        logic [63:0] mc;
        logic [63:0] ec;
        logic        ie;
        logic        iv;
    } exp_t;

    logic evrClk;
    logic rst;

    marker_interval_monitor_if #(.INTERVAL_WIDTH(29), .COUNT_WIDTH(16),
        .TIMESTAMP_WIDTH(TS_W), .TOL_WIDTH(12)) if0 ();
    marker_interval_monitor_if #(.INTERVAL_WIDTH(8), .COUNT_WIDTH(16),
        .TIMESTAMP_WIDTH(TS_W), .TOL_WIDTH(12)) if1 ();

    marker_interval_monitor #(.INTERVAL_WIDTH(29), .COUNT_WIDTH(16),
        .TIMESTAMP_WIDTH(TS_W), .TOL_WIDTH(12)) dut0 (
        .evrClk(evrClk), .sysCSRstrobe(rst), .mon(if0));
    marker_interval_monitor #(.INTERVAL_WIDTH(8), .COUNT_WIDTH(16),
        .TIMESTAMP_WIDTH(TS_W), .TOL_WIDTH(12)) dut1 (
        .evrClk(evrClk), .sysCSRstrobe(rst), .mon(if1));

    // ---------------- clock ----------------
    initial evrClk = 1'b0;
    always #5 evrClk = ~evrClk;

    // ---------------- bookkeeping ----------------
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [63:0] ts = TS_BASE;
    exp_t        q0[$];
    exp_t        q1[$];
    int          upd0 = 0;
    int          upd1 = 0;

    // reference model state, index 0 = dut0, 1 = dut1
    bit          m_armed[2];
    int          m_lastc[2];
    logic [63:0] m_imax[2];
    logic [63:0] m_min[2];
    logic [63:0] m_max[2];
    logic [63:0] m_li[2];
    logic [63:0] m_mc[2];
    logic [63:0] m_ec[2];
    bit          m_ie[2];
    bit          m_iv[2];
    logic [63:0] m_ts[2];
    longint      m_exp[2];
    longint      m_tol[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic snap(input int d, output logic [63:0] o_ts, o_li, o_mn, o_mx, o_mc, o_ec,
                        output logic o_ie, o_iv, o_tg, output logic [1:0] o_st);
        if (d == 0) begin
            o_ts = if0.markerTimestamp; o_li = 64'(if0.lastInterval);
            o_mn = 64'(if0.minInterval); o_mx = 64'(if0.maxInterval);
            o_mc = 64'(if0.markerCount); o_ec = 64'(if0.errorCount);
            o_ie = if0.intervalError; o_iv = if0.intervalValid;
            o_tg = if0.updateToggle; o_st = if0.fsm_state;
        end else begin
            o_ts = if1.markerTimestamp; o_li = 64'(if1.lastInterval);
            o_mn = 64'(if1.minInterval); o_mx = 64'(if1.maxInterval);
            o_mc = 64'(if1.markerCount); o_ec = 64'(if1.errorCount);
            o_ie = if1.intervalError; o_iv = if1.intervalValid;
            o_tg = if1.updateToggle; o_st = if1.fsm_state;
        end
    endtask

    // Hand-computed expectations for a DUT at a quiet point.
    task automatic check_vals(input string tag, input int d, input logic [63:0] li, mn, mx, mc, ec,
                              input logic ie, iv);
        logic [63:0] a_ts, a_li, a_mn, a_mx, a_mc, a_ec;
        logic a_ie, a_iv, a_tg;
        logic [1:0] a_st;
        snap(d, a_ts, a_li, a_mn, a_mx, a_mc, a_ec, a_ie, a_iv, a_tg, a_st);
        check($sformatf("%s_d%0d_lastInterval", tag, d), a_li, li);
        check($sformatf("%s_d%0d_minInterval", tag, d), a_mn, mn);
        check($sformatf("%s_d%0d_maxInterval", tag, d), a_mx, mx);
        check($sformatf("%s_d%0d_markerCount", tag, d), a_mc, mc);
        check($sformatf("%s_d%0d_errorCount", tag, d), a_ec, ec);
        check($sformatf("%s_d%0d_intervalError", tag, d), 64'(a_ie), 64'(ie));
        check($sformatf("%s_d%0d_intervalValid", tag, d), 64'(a_iv), 64'(iv));
    endtask

    task automatic check_reset_state(input string tag, input int d);
        logic [63:0] a_ts, a_li, a_mn, a_mx, a_mc, a_ec;
        logic a_ie, a_iv, a_tg;
        logic [1:0] a_st;
        check_vals(tag, d, 64'd0, (d == 0) ? WIDE_MAX : NARR_MAX, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        snap(d, a_ts, a_li, a_mn, a_mx, a_mc, a_ec, a_ie, a_iv, a_tg, a_st);
        check($sformatf("%s_d%0d_markerTimestamp", tag, d), a_ts, 64'd0);
        check($sformatf("%s_d%0d_updateToggle", tag, d), 64'(a_tg), 64'd0);
        check($sformatf("%s_d%0d_fsm_state", tag, d), 64'(a_st), 64'd0);
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset(input int d);
        m_armed[d] = 1'b0; m_lastc[d] = 0;
        m_min[d] = m_imax[d]; m_max[d] = 0; m_li[d] = 0;
        m_mc[d] = 0; m_ec[d] = 0; m_ie[d] = 1'b0; m_iv[d] = 1'b0; m_ts[d] = 0;
    endtask

    task automatic model_edge(input int d);
        exp_t   r;
        longint p, dev;
        bit     ovf, err;
        if (m_armed[d]) begin
            p   = longint'(cyc - m_lastc[d]);
            ovf = (p >= longint'(m_imax[d]));
            dev = p - m_exp[d];
            if (dev < 0) dev = -dev;
            err = ovf || ((m_exp[d] != 0) && (dev > m_tol[d]));
            m_iv[d] = 1'b1;
            m_li[d] = ovf ? m_imax[d] : 64'(p);
            if (!ovf) begin
                if (64'(p) < m_min[d]) m_min[d] = 64'(p);
                if (64'(p) > m_max[d]) m_max[d] = 64'(p);
            end
            if (err) begin
                m_ie[d] = 1'b1;
                if (m_ec[d] != 64'hFFFF) m_ec[d] = m_ec[d] + 1;
            end
        end
        m_armed[d] = 1'b1;
        m_lastc[d] = cyc;
        if (m_mc[d] != 64'hFFFF) m_mc[d] = m_mc[d] + 1;
        m_ts[d] = ts;
        r.vis = cyc + 1; r.ts = ts; r.last = m_li[d]; r.mn = m_min[d]; r.mx = m_max[d];
        r.mc = m_mc[d]; r.ec = m_ec[d]; r.ie = m_ie[d]; r.iv = m_iv[d];
        if (d == 0) q0.push_back(r); else q1.push_back(r);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge evrClk);
            #1;
            cyc++;
            ts = TS_BASE + 64'(cyc);
            if0.evrTimestamp = ts;
            if1.evrTimestamp = ts;
        end
    endtask

    task automatic set_marker(input int d, input logic v);
        if (d == 0) if0.marker = v; else if1.marker = v;
    endtask

    task automatic set_cfg(input int d, input int e, input int t);
        m_exp[d] = e; m_tol[d] = t;
        if (d == 0) begin
            if0.expectedInterval = 29'(e); if0.tolerance = 12'(t);
        end else begin
            if1.expectedInterval = 8'(e); if1.tolerance = 12'(t);
        end
    endtask

    // Rising edge now, high 3 cycles, next edge may follow `gap` cycles later.
    task automatic pulse(input int d, input int gap);
        set_marker(d, 1'b1);
        model_edge(d);
        tick(3);
        set_marker(d, 1'b0);
        tick(gap - 3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        tick(2);
        rst = 1'b0;
        tick(3);
    endtask

    // ---------------- monitor ----------------
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;

    task automatic compare_rec(input int d, input exp_t r);
        logic [63:0] a_ts, a_li, a_mn, a_mx, a_mc, a_ec;
        logic a_ie, a_iv, a_tg;
        logic [1:0] a_st;
        snap(d, a_ts, a_li, a_mn, a_mx, a_mc, a_ec, a_ie, a_iv, a_tg, a_st);
        check($sformatf("upd_d%0d_latency_cycle", d), 64'(cyc), 64'(r.vis));
        check($sformatf("upd_d%0d_markerTimestamp", d), a_ts, r.ts);
        check($sformatf("upd_d%0d_lastInterval", d), a_li, r.last);
        check($sformatf("upd_d%0d_minInterval", d), a_mn, r.mn);
        check($sformatf("upd_d%0d_maxInterval", d), a_mx, r.mx);
        check($sformatf("upd_d%0d_markerCount", d), a_mc, r.mc);
        check($sformatf("upd_d%0d_errorCount", d), a_ec, r.ec);
        check($sformatf("upd_d%0d_intervalError", d), 64'(a_ie), 64'(r.ie));
        check($sformatf("upd_d%0d_intervalValid", d), 64'(a_iv), 64'(r.iv));
    endtask

    always @(negedge evrClk) begin
        exp_t r;
        if (rst) begin
            prev0 = if0.updateToggle;
            prev1 = if1.updateToggle;
        end else begin
            if (if0.updateToggle !== prev0) begin
                prev0 = if0.updateToggle;
                upd0++;
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_update_d0 actual=toggle expected=no_update (cycle %0d)", cyc);
                end else begin
                    r = q0.pop_front();
                    compare_rec(0, r);
                end
            end
            if (if1.updateToggle !== prev1) begin
                prev1 = if1.updateToggle;
                upd1++;
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_update_d1 actual=toggle expected=no_update (cycle %0d)", cyc);
                end else begin
                    r = q1.pop_front();
                    compare_rec(1, r);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] saved_ts;
        m_imax[0] = WIDE_MAX;
        m_imax[1] = NARR_MAX;
        rst = 1'b1;
        if0.marker = 1'b1;      // held high through reset release
        if1.marker = 1'b0;
        if0.evrTimestamp = ts;
        if1.evrTimestamp = ts;
        set_cfg(0, 100, 0);
        set_cfg(1, 0, 0);
        model_reset(0);
        model_reset(1);
        tick(3);
        check_reset_state("rst", 0);
        check_reset_state("rst", 1);

        // Marker high across release: no edge until it falls and rises again.
        rst = 1'b0;
        tick(8);
        check("held_d0_markerCount", 64'(if0.markerCount), 64'd0);
        check("held_d0_updateToggle", 64'(if0.updateToggle), 64'd0);
        if0.marker = 1'b0;
        tick(10);

        // Nominal 100-cycle period, exact tolerance.
        pulse(0, 100); pulse(0, 100); pulse(0, 100); pulse(0, 20);
        check_vals("nominal", 0, 64'd100, 64'd100, 64'd100, 64'd4, 64'd0, 1'b0, 1'b1);
        check("nominal_d0_updates", 64'(upd0), 64'd4);
        check("nominal_d0_updateToggle", 64'(if0.updateToggle), 64'd0);
        check("nominal_d0_fsm_state", 64'(if0.fsm_state), 64'd2);

        // Tolerance window 100 +/- 3: 98 ok, 105 error, 103 on the boundary ok.
        do_reset();
        set_cfg(0, 100, 3);
        pulse(0, 100); pulse(0, 98); pulse(0, 105); pulse(0, 103); pulse(0, 20);
        check_vals("tol", 0, 64'd103, 64'd98, 64'd105, 64'd5, 64'd1, 1'b1, 1'b1);

        // Reset in the middle of an interval after five markers.
        do_reset();
        set_cfg(0, 0, 0);
        pulse(0, 60); pulse(0, 60); pulse(0, 60); pulse(0, 60); pulse(0, 20);
        check("midrst_d0_markerCount_before", 64'(if0.markerCount), 64'd5);
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        check_reset_state("midrst", 0);
        tick(2);
        rst = 1'b0;
        tick(5);
        pulse(0, 70); pulse(0, 20);
        check_vals("after_rst", 0, 64'd70, 64'd70, 64'd70, 64'd2, 64'd0, 1'b0, 1'b1);

        // Timestamp capture with checking disabled.
        do_reset();
        set_cfg(0, 0, 5);
        pulse(0, 77); pulse(0, 13);
        saved_ts = ts;
        pulse(0, 250); pulse(0, 20);
        check("ts_d0_errorCount", 64'(if0.errorCount), 64'd0);
        check("ts_d0_markerTimestamp", if0.markerTimestamp, saved_ts + 64'd250);
        check("ts_d0_markerTimestamp_abs", if0.markerTimestamp, TS_BASE + 64'(cyc - 20));

        // 8-bit counter: a 300-cycle gap saturates and counts as an error.
        do_reset();
        set_cfg(1, 0, 0);
        pulse(1, 300);
        pulse(1, 50);
        check_vals("ovf", 1, 64'd255, 64'd255, 64'd0, 64'd2, 64'd1, 1'b1, 1'b1);
        pulse(1, 20);
        check_vals("post_ovf", 1, 64'd50, 64'd50, 64'd50, 64'd3, 64'd1, 1'b1, 1'b1);

        tick(5);
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
